// File: rtl/matmul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// matmul_seq_ctrl
// Sequencer for the matmul accelerator datapath. One start command runs
// CLEAR -> [BIAS] -> FEED -> WB -> DONE. Each state drives the PE array
// strobes and the scratchpad (SP) read/write ports for its phase.
//
// Optional feature (compile-time macro MATMUL_SEQ_CTRL_OVF_EN):
//   defined     : flags_o collects per-PE overflow seen during FEED or during
//                 a bias_ld_o cycle. The flags stay set until the next CLEAR
//                 or until reset.
//   not defined : flags_o is tied to 0 and pe_ovf_i is ignored.
//
// Ports:
//   clk_i, rst_i            clock (rising edge), synchronous active-high reset
//   start_i                 start request, sampled only in IDLE
//   n/k/m_dim_i             matrix dimensions minus 1 (latched at start)
//   mode_bias_i             1 = preload PE accumulators with the bias rows
//   read/write_target_i     SP slot holding the bias / receiving C
//   pe_ovf_i                per-PE overflow indication
//   busy_o                  high whenever the sequencer is not in IDLE
//   pe_clear_o, bias_ld_o   PE accumulator clear / bias row preload strobes
//   feed_valid_o/feed_idx_o operand feed step and its index
//   sp_rd_*/sp_wr_*         SP read (bias) and write (C row) ports
//   wb_row_o                PE row currently placed on the SP write bus
//   done_o                  one-cycle completion pulse
//   flags_o                 sticky per-PE overflow flags
// -----------------------------------------------------------------------------
module matmul_seq_ctrl #(
    parameter int MAX_DIM     = 4,
    parameter int SP_NTARGETS = 4,
    parameter int DW          = $clog2(MAX_DIM),
    parameter int SPAW        = $clog2(SP_NTARGETS*MAX_DIM)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             start_i,
    input  logic [DW-1:0]                    n_dim_i,
    input  logic [DW-1:0]                    k_dim_i,
    input  logic [DW-1:0]                    m_dim_i,
    input  logic                             mode_bias_i,
    input  logic [$clog2(SP_NTARGETS)-1:0]   read_target_i,
    input  logic [$clog2(SP_NTARGETS)-1:0]   write_target_i,
    input  logic [MAX_DIM*MAX_DIM-1:0]       pe_ovf_i,
    output logic                             busy_o,
    output logic                             pe_clear_o,
    output logic                             bias_ld_o,
    output logic                             feed_valid_o,
    output logic [$clog2(3*MAX_DIM)-1:0]     feed_idx_o,
    output logic                             sp_rd_en_o,
    output logic [SPAW-1:0]                  sp_rd_addr_o,
    output logic                             sp_wr_en_o,
    output logic [SPAW-1:0]                  sp_wr_addr_o,
    output logic [DW-1:0]                    wb_row_o,
    output logic                             done_o,
    output logic [MAX_DIM*MAX_DIM-1:0]       flags_o
);

    localparam int TW  = $clog2(SP_NTARGETS);
    localparam int CW  = $clog2(3*MAX_DIM);
    localparam int NPE = MAX_DIM*MAX_DIM;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_BIAS, S_FEED, S_WB, S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;

    // Configuration captured when a start is accepted.
    logic [DW-1:0]   r_n;
    logic [DW-1:0]   r_k;
    logic [DW-1:0]   r_m;
    logic            r_bias;
    logic [TW-1:0]   r_rd_tgt;
    logic [TW-1:0]   r_wr_tgt;

    // The SP read has one cycle of latency. The preload strobe therefore
    // trails the read strobe by one cycle. Because of this, the strobe for the
    // last bias row lands in the first FEED cycle.
    logic            r_bias_ld;

    logic [DW-1:0]   w_row;
    logic            w_row_last;
    logic [CW-1:0]   w_feed_last;

    // Rows never exceed MAX_DIM-1, so the low bits of the counter are the row.
    assign w_row       = r_cnt[DW-1:0];
    assign w_row_last  = (w_row == r_n);
    // F-1 = (K+N+M-2)-1 = k_field + n_field + m_field
    assign w_feed_last = CW'(r_n) + CW'(r_k) + CW'(r_m);

    // State register and step counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_n       <= '0;
            r_k       <= '0;
            r_m       <= '0;
            r_bias    <= 1'b0;
            r_rd_tgt  <= '0;
            r_wr_tgt  <= '0;
            r_bias_ld <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start_i) begin
                r_n      <= n_dim_i;
                r_k      <= k_dim_i;
                r_m      <= m_dim_i;
                r_bias   <= mode_bias_i;
                r_rd_tgt <= read_target_i;
                r_wr_tgt <= write_target_i;
            end
            r_bias_ld <= (r_state == S_BIAS);
        end
    end

    // Next-state logic. The counter restarts from 0 at every state change.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = '0;
        case (r_state)
            S_IDLE:  if (start_i) w_state_next = S_CLEAR;
            S_CLEAR: w_state_next = r_bias ? S_BIAS : S_FEED;
            S_BIAS: begin
                if (w_row_last) w_state_next = S_FEED;
                else            w_cnt_next   = r_cnt + 1'b1;
            end
            S_FEED: begin
                if (r_cnt == w_feed_last) w_state_next = S_WB;
                else                      w_cnt_next   = r_cnt + 1'b1;
            end
            S_WB: begin
                if (w_row_last) w_state_next = S_DONE;
                else            w_cnt_next   = r_cnt + 1'b1;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output logic: Moore outputs decoded from the state and the counter.
    always_comb begin
        busy_o       = (r_state != S_IDLE);
        pe_clear_o   = 1'b0;
        bias_ld_o    = r_bias_ld;
        feed_valid_o = 1'b0;
        feed_idx_o   = '0;
        sp_rd_en_o   = 1'b0;
        sp_rd_addr_o = '0;
        sp_wr_en_o   = 1'b0;
        sp_wr_addr_o = '0;
        wb_row_o     = '0;
        done_o       = 1'b0;
        case (r_state)
            S_CLEAR: pe_clear_o = 1'b1;
            S_BIAS: begin
                sp_rd_en_o   = 1'b1;
                sp_rd_addr_o = (SPAW'(r_rd_tgt) << DW) + SPAW'(w_row);
            end
            S_FEED: begin
                feed_valid_o = 1'b1;
                feed_idx_o   = r_cnt;
            end
            S_WB: begin
                sp_wr_en_o   = 1'b1;
                sp_wr_addr_o = (SPAW'(r_wr_tgt) << DW) + SPAW'(w_row);
                wb_row_o     = w_row;
            end
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

`ifdef MATMUL_SEQ_CTRL_OVF_EN
    // Overflow is meaningful only while operands or bias enter the array.
    logic w_ovf_window;
    assign w_ovf_window = (r_state == S_FEED) || r_bias_ld;

    genvar gi;
    generate
        for (gi = 0; gi < NPE; gi++) begin : g_flag
            logic r_flag;
            always_ff @(posedge clk_i) begin
                if (rst_i || r_state == S_CLEAR)
                    r_flag <= 1'b0;
                else if (w_ovf_window && pe_ovf_i[gi])
                    r_flag <= 1'b1;
            end
            assign flags_o[gi] = r_flag;
        end
    endgenerate
`else
    logic w_unused_ovf;
    assign w_unused_ovf = ^pe_ovf_i;
    assign flags_o      = {NPE{1'b0}};
`endif

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_matmul_seq_ctrl
// Directed bench for matmul_seq_ctrl. Each start command pushes the expected
// per-cycle output vector of the whole run onto a scoreboard queue. A monitor
// pops one entry per clock and compares it against the DUT outputs. When the
// queue is empty, the monitor expects the all-zero IDLE vector. Overflow flags
// are checked every cycle against a bench-maintained expected value.
// -----------------------------------------------------------------------------
module tb_matmul_seq_ctrl;

    localparam int MAX_DIM     = 4;
    localparam int SP_NTARGETS = 4;
    localparam int DW          = 2;
    localparam int TW          = 2;
    localparam int SPAW        = 4;
    localparam int CW          = 4;
    localparam int NPE         = 16;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic [DW-1:0]     n_dim_i, k_dim_i, m_dim_i;
    logic              mode_bias_i;
    logic [TW-1:0]     read_target_i, write_target_i;
    logic [NPE-1:0]    pe_ovf_i;
    logic              busy_o, pe_clear_o, bias_ld_o, feed_valid_o;
    logic [CW-1:0]     feed_idx_o;
    logic              sp_rd_en_o, sp_wr_en_o, done_o;
    logic [SPAW-1:0]   sp_rd_addr_o, sp_wr_addr_o;
    logic [DW-1:0]     wb_row_o;
    logic [NPE-1:0]    flags_o;

    always #5 clk = ~clk;

    matmul_seq_ctrl #(.MAX_DIM(MAX_DIM), .SP_NTARGETS(SP_NTARGETS)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .n_dim_i(n_dim_i), .k_dim_i(k_dim_i), .m_dim_i(m_dim_i),
        .mode_bias_i(mode_bias_i),
        .read_target_i(read_target_i), .write_target_i(write_target_i),
        .pe_ovf_i(pe_ovf_i),
        .busy_o(busy_o), .pe_clear_o(pe_clear_o), .bias_ld_o(bias_ld_o),
        .feed_valid_o(feed_valid_o), .feed_idx_o(feed_idx_o),
        .sp_rd_en_o(sp_rd_en_o), .sp_rd_addr_o(sp_rd_addr_o),
        .sp_wr_en_o(sp_wr_en_o), .sp_wr_addr_o(sp_wr_addr_o),
        .wb_row_o(wb_row_o), .done_o(done_o), .flags_o(flags_o)
    );

    typedef struct packed {
        logic            busy;
        logic            clr;
        logic            bld;
        logic            fv;
        logic [CW-1:0]   fidx;
        logic            rd_en;
        logic [SPAW-1:0] rd_addr;
        logic            wr_en;
        logic [SPAW-1:0] wr_addr;
        logic [DW-1:0]   wb_row;
        logic            done;
    } exp_t;

    exp_t           exp_q[$];
    string          tag_q[$];
    logic [NPE-1:0] model_flags = '0;
    bit             mon_en = 1'b0;
    int             n_cmp = 0;
    int             n_bad = 0;

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        exp_t  e;
        exp_t  a;
        string tag;
        #1;
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                tag = tag_q.pop_front();
            end else begin
                e   = '0;
                tag = "idle";
            end
            a = {busy_o, pe_clear_o, bias_ld_o, feed_valid_o, feed_idx_o,
                 sp_rd_en_o, sp_rd_addr_o, sp_wr_en_o, sp_wr_addr_o,
                 wb_row_o, done_o};
            $display("t=%0t %s outputs=%h flags=%h", $time, tag, a, flags_o);
            n_cmp++;
            assert (a === e) else begin
                n_bad++;
                $error("FAIL %s: observed=%h expected=%h", tag, a, e);
            end
            n_cmp++;
            assert (flags_o === model_flags) else begin
                n_bad++;
                $error("FAIL %s_flags: observed=%h expected=%h", tag, flags_o, model_flags);
            end
        end
    end

    // Reference model: the expected output vector for every cycle of one run,
    // starting with the cycle after the accepting edge.
    task automatic push_run(input int n, input int k, input int m, input bit bias,
                            input int rt, input int wt, input string name,
                            output int lat);
        int   nn, ff;
        exp_t e;
        nn = n + 1;
        ff = (k + 1) + nn + (m + 1) - 2;
        lat = 2 + ff + nn + (bias ? nn : 0);
        e = '0; e.busy = 1'b1; e.clr = 1'b1;
        exp_q.push_back(e); tag_q.push_back({name, "_clear"});
        if (bias) begin
            for (int r = 0; r < nn; r++) begin
                e = '0; e.busy = 1'b1; e.rd_en = 1'b1;
                e.rd_addr = SPAW'(rt*MAX_DIM + r);
                e.bld = (r > 0);
                exp_q.push_back(e); tag_q.push_back($sformatf("%s_bias%0d", name, r));
            end
        end
        for (int i = 0; i < ff; i++) begin
            e = '0; e.busy = 1'b1; e.fv = 1'b1; e.fidx = CW'(i);
            e.bld = bias && (i == 0);
            exp_q.push_back(e); tag_q.push_back($sformatf("%s_feed%0d", name, i));
        end
        for (int r = 0; r < nn; r++) begin
            e = '0; e.busy = 1'b1; e.wr_en = 1'b1;
            e.wr_addr = SPAW'(wt*MAX_DIM + r); e.wb_row = DW'(r);
            exp_q.push_back(e); tag_q.push_back($sformatf("%s_wb%0d", name, r));
        end
        e = '0; e.busy = 1'b1; e.done = 1'b1;
        exp_q.push_back(e); tag_q.push_back({name, "_done"});
    endtask

    // Call just after a falling edge. The start is accepted at the next rising edge.
    task automatic start_cmd(input int n, input int k, input int m, input bit bias,
                             input int rt, input int wt, input string name,
                             output int lat);
        n_dim_i        = DW'(n);
        k_dim_i        = DW'(k);
        m_dim_i        = DW'(m);
        mode_bias_i    = bias;
        read_target_i  = TW'(rt);
        write_target_i = TW'(wt);
        start_i        = 1'b1;
        push_run(n, k, m, bias, rt, wt, name, lat);
    endtask

    task automatic wait_drain(input string name);
        int c = 0;
        while (exp_q.size() != 0 && c < 60) begin
            @(negedge clk);
            c++;
        end
        n_cmp++;
        assert (exp_q.size() == 0) else begin
            n_bad++;
            $error("FAIL drain_%s: remaining=%0d required=0", name, exp_q.size());
            exp_q.delete();
            tag_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int lat, lat2;
        rst_i = 1'b1; start_i = 1'b0; n_dim_i = '0; k_dim_i = '0; m_dim_i = '0;
        mode_bias_i = 1'b0; read_target_i = '0; write_target_i = '0; pe_ovf_i = '0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;                       // reset state is checked from here on
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        repeat (2) @(negedge clk);

        // 4x4x4, no bias, C to slot 2
        start_cmd(3, 3, 3, 1'b0, 0, 2, "full", lat);
        @(negedge clk); start_i = 1'b0;
        wait_drain("full");

        // N=2 K=3 M=1 with bias from slot 2, C to slot 1
        start_cmd(1, 2, 0, 1'b1, 2, 1, "bias", lat);
        @(negedge clk); start_i = 1'b0;
        wait_drain("bias");

        // all dimensions 1
        start_cmd(0, 0, 0, 1'b0, 0, 3, "dim1", lat);
        @(negedge clk); start_i = 1'b0;
        wait_drain("dim1");

        // start held high while inputs change mid-run. Expect one run, one
        // IDLE gap, then a second run that uses the values present in that gap.
        start_cmd(3, 1, 2, 1'b0, 1, 3, "held_a", lat);
        exp_q.push_back('0); tag_q.push_back("held_gap");
        push_run(1, 0, 3, 1'b1, 3, 0, "held_b", lat2);
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            n_dim_i        = DW'($urandom_range(0, 3));
            k_dim_i        = DW'($urandom_range(0, 3));
            m_dim_i        = DW'($urandom_range(0, 3));
            mode_bias_i    = 1'($urandom_range(0, 1));
            read_target_i  = TW'($urandom_range(0, 3));
            write_target_i = TW'($urandom_range(0, 3));
        end
        @(negedge clk);                      // DONE cycle of the first run
        n_dim_i = 2'd1; k_dim_i = 2'd0; m_dim_i = 2'd3; mode_bias_i = 1'b1;
        read_target_i = 2'd3; write_target_i = 2'd0;
        @(negedge clk);                      // IDLE gap: accepted here
        @(negedge clk); start_i = 1'b0;
        wait_drain("held");

        // reset asserted during FEED aborts the run with no done
        start_cmd(3, 3, 3, 1'b0, 1, 1, "abort", lat);
        @(negedge clk); start_i = 1'b0;
        repeat (4) @(negedge clk);
        rst_i = 1'b1;
        exp_q.delete(); tag_q.delete();
        model_flags = '0;
        @(negedge clk); rst_i = 1'b0;
        repeat (2) @(negedge clk);
        start_cmd(2, 1, 3, 1'b0, 0, 2, "after_rst", lat);
        @(negedge clk); start_i = 1'b0;
        wait_drain("after_rst");

        // overflow on PE 5 during FEED; the flag stays set through DONE and IDLE
        start_cmd(3, 3, 3, 1'b0, 0, 0, "ovf_a", lat);
        @(negedge clk); start_i = 1'b0;
        repeat (3) @(negedge clk);           // third FEED cycle
        pe_ovf_i[5] = 1'b1;
`ifdef MATMUL_SEQ_CTRL_OVF_EN
        model_flags = 16'h0020;
`endif
        @(negedge clk); pe_ovf_i = '0;
        wait_drain("ovf_a");
        pe_ovf_i[9] = 1'b1;                  // outside the capture window
        @(negedge clk); pe_ovf_i = '0;
        @(negedge clk);
        start_cmd(0, 1, 0, 1'b0, 0, 1, "ovf_b", lat);
        @(negedge clk); start_i = 1'b0;      // CLEAR cycle; cleared after it
        model_flags = '0;
        wait_drain("ovf_b");

        mon_en = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
